// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller:
// FSM state encoding, coin codes and the coin-to-cents lookup.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_25   = 2'd3;

    localparam logic [7:0] NICKEL = 8'd5;

    function automatic logic [7:0] coin_val(input logic [1:0] code);
        logic [7:0] cents;
        case (code)
            COIN_5:  cents = 8'd5;
            COIN_10: cents = 8'd10;
            COIN_25: cents = 8'd25;
            default: cents = 8'd0;
        endcase
        return cents;
    endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Coin edge detector: flags the first cycle of a nonzero coin code after an
// idle (zero) sample and supplies that coin's value in cents.
module vend_coin_decode
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    output logic                coin_valid,
    output logic [CREDIT_W-1:0] coin_value
);

    logic [1:0] coin_prev_q;
    logic [1:0] coin_prev_d;

    // Next value of the previous-sample register.
    always_comb begin
        coin_prev_d = coin;
    end

    // Previous coin sample register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coin_prev_q <= COIN_NONE;
        end else begin
            coin_prev_q <= coin_prev_d;
        end
    end

    assign coin_valid = (coin != COIN_NONE) && (coin_prev_q == COIN_NONE);
    assign coin_value = CREDIT_W'(coin_val(coin));

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credits coins, vends on select, and
// returns change as a stream of nickel pulses. Optional build macro
// VEND_AUTO_SELECT_EN vends item 0 automatically once its price is reached.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                          N_ITEMS    = 2,
    parameter int                          CREDIT_W   = 8,
    parameter int                          MAX_CREDIT = 100,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd20, 8'd15}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic [N_ITEMS-1:0]  select,
    input  logic                cancel,
    output logic [N_ITEMS-1:0]  vend,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                deny,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    function automatic bit prices_ok();
        bit ok;
        int p;
        ok = 1'b1;
        for (int i = 0; i < N_ITEMS; i++) begin
            p = int'(PRICE_LIST[i*CREDIT_W +: CREDIT_W]);
            if (p == 32'sd0 || (p % 32'sd5) != 32'sd0 || p > MAX_CREDIT) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    if (!prices_ok() || N_ITEMS < 1 || N_ITEMS > 8 ||
        MAX_CREDIT >= (32'sd1 <<< CREDIT_W)) begin : g_cfg_err
        $error("vend_ctrl_multi: illegal N_ITEMS, MAX_CREDIT or PRICE_LIST");
    end

    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);
`ifdef VEND_AUTO_SELECT_EN
    localparam logic [CREDIT_W-1:0] PRICE0   = PRICE_LIST[CREDIT_W-1:0];
    localparam logic [N_ITEMS-1:0]  ITEM0_OH = N_ITEMS'(1'b1);
`endif

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [N_ITEMS-1:0]  vend_q, vend_d;
    logic                nickel_q, nickel_d;
    logic                reject_q, reject_d;
    logic                deny_q, deny_d;
    logic                busy_q, busy_d;

    logic                coin_valid_s;
    logic [CREDIT_W-1:0] coin_value_s;
    logic                coin_ok_s;
    logic [CREDIT_W-1:0] credit_coin_s;
    logic                sel_hit_s;
    logic [N_ITEMS-1:0]  sel_oh_s;
    logic [CREDIT_W-1:0] sel_price_s;

    vend_coin_decode #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_decode (
        .clock      (clock),
        .reset      (reset),
        .coin       (coin),
        .coin_valid (coin_valid_s),
        .coin_value (coin_value_s)
    );

    // Coins are credited only while idle or accumulating, and only below the ceiling.
    always_comb begin
        coin_ok_s = coin_valid_s && ((state_q == IDLE) || (state_q == ACCUM)) &&
                    (({1'b0, credit_q} + {1'b0, coin_value_s}) <= MAX_C);
        if (coin_ok_s) begin
            credit_coin_s = credit_q + coin_value_s;
        end else begin
            credit_coin_s = credit_q;
        end
    end

    // Lowest-index select wins; descending scan lets low bits overwrite.
    always_comb begin
        sel_hit_s   = 1'b0;
        sel_oh_s    = '0;
        sel_price_s = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (select[i]) begin
                sel_hit_s   = 1'b1;
                sel_oh_s    = '0;
                sel_oh_s[i] = 1'b1;
                sel_price_s = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
            end else begin
                sel_hit_s = sel_hit_s;
            end
        end
    end

    // Next state and next registered outputs. Each state's pulse is set on the
    // edge that enters it, so the pulse and busy line up with the state.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        vend_d   = '0;
        nickel_d = 1'b0;
        reject_d = coin_valid_s && !coin_ok_s;
        deny_d   = 1'b0;
        case (state_q)
            IDLE: begin
                credit_d = credit_coin_s;
                deny_d   = sel_hit_s;
                if (coin_ok_s) begin
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                credit_d = credit_coin_s;
                if (cancel) begin
                    state_d  = CHANGE;
                    nickel_d = 1'b1;
                    credit_d = credit_coin_s - NICKEL_C;
                end else if (sel_hit_s) begin
                    // Judged on pre-coin credit; a same-cycle coin is still kept.
                    if (credit_q >= sel_price_s) begin
                        state_d  = VEND;
                        vend_d   = sel_oh_s;
                        credit_d = credit_coin_s - sel_price_s;
                    end else begin
                        deny_d = 1'b1;
                    end
`ifdef VEND_AUTO_SELECT_EN
                end else if (credit_q >= PRICE0) begin
                    state_d  = VEND;
                    vend_d   = ITEM0_OH;
                    credit_d = credit_coin_s - PRICE0;
`endif
                end else begin
                    state_d = ACCUM;
                end
            end
            VEND, CHANGE: begin
                if (credit_q >= NICKEL_C) begin
                    state_d  = CHANGE;
                    nickel_d = 1'b1;
                    credit_d = credit_q - NICKEL_C;
                end else begin
                    state_d  = IDLE;
                    credit_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    // State, credit and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            vend_q   <= '0;
            nickel_q <= 1'b0;
            reject_q <= 1'b0;
            deny_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            nickel_q <= nickel_d;
            reject_q <= reject_d;
            deny_q   <= deny_d;
            busy_q   <= busy_d;
        end
    end

    assign vend          = vend_q;
    assign change_nickel = nickel_q;
    assign coin_reject   = reject_q;
    assign deny          = deny_q;
    assign credit        = credit_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed steps then random actions,
// each scored against a transaction-level credit model.
module tb_vend_ctrl_multi;

    localparam int N    = 2;
    localparam int MAXC = 100;
`ifdef VEND_AUTO_SELECT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    int price [N] = '{15, 20};

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic [1:0]   coin   = 2'd0;
    logic [N-1:0] select = '0;
    logic         cancel = 1'b0;
    logic [N-1:0] vend;
    logic         change_nickel, coin_reject, deny, busy;
    logic [7:0]   credit;

    int checks = 0;
    int errors = 0;

    int m_credit = 0;
    int ex_credit1;
    int ex_vend [N];
    int ex_nick, ex_deny, ex_rej;
    bit ex_sel_vend;

    int cyc;
    int n_vend [N];
    int n_nick, n_deny, n_rej, bad_overlap, bad_busy, vend_cyc, nick_first, nick_last;

    vend_ctrl_multi dut (
        .clock         (clock),
        .reset         (reset),
        .coin          (coin),
        .select        (select),
        .cancel        (cancel),
        .vend          (vend),
        .change_nickel (change_nickel),
        .coin_reject   (coin_reject),
        .deny          (deny),
        .credit        (credit),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cents(input logic [1:0] code);
        return (code == 2'd1) ? 5 : (code == 2'd2) ? 10 : (code == 2'd3) ? 25 : 0;
    endfunction

    // Transaction-level model of one action: coin edge, select and/or cancel.
    task automatic model(input logic [1:0] code, input logic [N-1:0] sel, input bit can);
        int v, pre, idx;
        v = cents(code);
        pre = m_credit;
        for (int i = 0; i < N; i++) ex_vend[i] = 0;
        ex_nick = 0; ex_deny = 0; ex_rej = 0; ex_sel_vend = 1'b0;
        if (v > 0) begin
            if (pre + v > MAXC) ex_rej = 1;
            else m_credit += v;
        end
        ex_credit1 = m_credit;
        idx = -1;
        for (int i = N - 1; i >= 0; i--) if (sel[i]) idx = i;
        if (can && pre > 0) begin
            ex_nick = m_credit / 5;
            m_credit = 0;
        end else if (idx >= 0) begin
            if (pre >= price[idx]) begin
                ex_vend[idx] = 1;
                ex_sel_vend = 1'b1;
                ex_nick = (m_credit - price[idx]) / 5;
                m_credit = 0;
            end else begin
                ex_deny = 1;
            end
        end
        if (AUTO && m_credit >= price[0]) begin
            ex_vend[0]++;
            ex_nick += (m_credit - price[0]) / 5;
            m_credit = 0;
        end
    endtask

    task automatic clear_counts();
        cyc = 0; n_nick = 0; n_deny = 0; n_rej = 0;
        bad_overlap = 0; bad_busy = 0; vend_cyc = 0; nick_first = 0; nick_last = 0;
        for (int i = 0; i < N; i++) n_vend[i] = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (vend[i] === 1'b1) begin
                n_vend[i]++;
                if (vend_cyc == 0) vend_cyc = cyc;
            end
        end
        if (change_nickel === 1'b1) begin
            n_nick++;
            if (nick_first == 0) nick_first = cyc;
            nick_last = cyc;
            if (busy !== 1'b1) bad_busy++;
        end
        if (vend != '0 && busy !== 1'b1) bad_busy++;
        if ($countones(vend) > 1 || (vend != '0 && change_nickel === 1'b1)) bad_overlap++;
        if (deny === 1'b1) n_deny++;
        if (coin_reject === 1'b1) n_rej++;
    endtask

    task automatic verify(input string tag);
        int any_vend;
        any_vend = 0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s vend%0d", tag, i), n_vend[i], ex_vend[i]);
            any_vend += ex_vend[i];
        end
        check({tag, " nickels"}, n_nick, ex_nick);
        check({tag, " deny"}, n_deny, ex_deny);
        check({tag, " reject"}, n_rej, ex_rej);
        check({tag, " credit"}, credit, m_credit);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " overlap"}, bad_overlap, 0);
        check({tag, " busy_pulse"}, bad_busy, 0);
        if (any_vend > 0) check({tag, " vend_lat"}, vend_cyc, ex_sel_vend ? 1 : 2);
        if (ex_nick > 0) begin
            check({tag, " nick_run"}, nick_last - nick_first + 1, ex_nick);
            check({tag, " nick_lat"}, nick_first, (any_vend > 0) ? vend_cyc + 1 : 1);
        end
    endtask

    task automatic act(input string tag, input logic [1:0] code, input int hold,
                       input logic [N-1:0] sel, input bit can);
        model(code, sel, can);
        clear_counts();
        coin = code; select = sel; cancel = can;
        tick();
        select = '0; cancel = 1'b0;
        if (code != 2'd0 && sel == '0 && !can) check({tag, " credit_next"}, credit, ex_credit1);
        for (int k = 1; k < hold; k++) tick();
        coin = 2'd0;
        repeat (24) tick();
        verify(tag);
    endtask

    initial begin
        logic [1:0]   r_code;
        logic [N-1:0] r_sel;
        int           r_hold;

        #20;
        check("rst vend", vend, 0);
        check("rst nickel", change_nickel, 0);
        check("rst reject", coin_reject, 0);
        check("rst deny", deny, 0);
        check("rst credit", credit, 0);
        check("rst busy", busy, 0);
        #32;
        reset = 1'b1;
        clear_counts();
        tick();
        check("post_rst credit", credit, 0);

`ifndef VEND_AUTO_SELECT_EN
        repeat (3) act("5c", 2'd1, 1, '0, 1'b0);
        act("sel0 exact", 2'd0, 1, 2'b01, 1'b0);

        act("5c", 2'd1, 1, '0, 1'b0);
        act("10c", 2'd2, 1, '0, 1'b0);
        act("25c", 2'd3, 2, '0, 1'b0);
        act("sel1 change", 2'd0, 1, 2'b10, 1'b0);

        act("10c", 2'd2, 1, '0, 1'b0);
        act("sel1 deny", 2'd0, 1, 2'b10, 1'b0);
        act("cancel", 2'd0, 1, '0, 1'b1);

        repeat (3) act("25c", 2'd3, 1, '0, 1'b0);
        act("10c", 2'd2, 1, '0, 1'b0);
        act("5c", 2'd1, 1, '0, 1'b0);
        act("25c over", 2'd3, 1, '0, 1'b0);
        act("10c to max", 2'd2, 1, '0, 1'b0);
        act("cancel max", 2'd0, 1, '0, 1'b1);

        // Coin arriving while change is being paid out must bounce.
        act("25c", 2'd3, 1, '0, 1'b0);
        act("10c", 2'd2, 1, '0, 1'b0);
        act("5c", 2'd1, 1, '0, 1'b0);
        model(2'd0, 2'b10, 1'b0);
        ex_rej = 1;
        clear_counts();
        select = 2'b10;
        tick();
        select = '0;
        tick();
        tick();
        coin = 2'd1;
        tick();
        coin = 2'd0;
        repeat (24) tick();
        verify("coin_in_change");

        // Reset during change payout.
        act("25c", 2'd3, 1, '0, 1'b0);
        act("10c", 2'd2, 1, '0, 1'b0);
        act("5c", 2'd1, 1, '0, 1'b0);
        clear_counts();
        select = 2'b10;
        tick();
        select = '0;
        tick();
        check("mid nickel", change_nickel, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async vend", vend, 0);
        check("async nickel", change_nickel, 0);
        check("async credit", credit, 0);
        check("async busy", busy, 0);
        #8;
        reset = 1'b1;
        m_credit = 0;
        clear_counts();
        repeat (24) tick();
        check("after_rst nickels", n_nick, 0);
        check("after_rst credit", credit, 0);
`else
        act("auto 5c", 2'd1, 1, '0, 1'b0);
        act("auto 10c", 2'd2, 1, '0, 1'b0);
        act("auto hold5", 2'd1, 3, '0, 1'b0);
        act("auto hold10", 2'd2, 3, '0, 1'b0);
        act("auto 25c", 2'd3, 1, '0, 1'b0);
`endif

        for (int n = 0; n < 80; n++) begin
            r_code = 2'($urandom_range(1, 3));
            r_sel  = N'($urandom_range(1, 3));
            r_hold = int'($urandom_range(1, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: act("rnd coin", r_code, r_hold, '0, 1'b0);
                6, 7:             act("rnd sel", 2'd0, 1, r_sel, 1'b0);
                8:                act("rnd cancel", 2'd0, 1, '0, 1'b1);
                default:          act("rnd coin_sel", r_code, 1, r_sel, 1'b0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised successor to the single-product newspaper vending controller. It accepts 5c, 10c and 25c coins and supports N_ITEMS products with individual prices. Vending happens on an explicit item select. Change is returned as a serial stream of nickel pulses. It sits between the coin acceptor / selection panel and the dispenser / change-hopper drivers.

Parameters:
- N_ITEMS, 2, number of products (1..8).
- CREDIT_W, 8, width of the credit register in cents.
- MAX_CREDIT, 100, credit ceiling in cents.
- PRICE_LIST, {8'd20, 8'd15}, packed CREDIT_W-bit prices; item i occupies bits [i*CREDIT_W +: CREDIT_W]. Every price must be a nonzero multiple of 5 and ≤ MAX_CREDIT; violations are caught by an elaboration-time check.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin  in  2  coin code: 0 none, 1 = 5c, 2 = 10c, 3 = 25c. Synchronous to clock; held ≥1 cycle; must return to 0 between coins.
- select  in  N_ITEMS  item request; one cycle is sufficient.
- cancel  in  1  refund request.
- vend  out  N_ITEMS  one-cycle dispense pulse, one-hot.
- change_nickel  out  1  one-cycle pulse; each pulse returns 5c.
- coin_reject  out  1  one-cycle pulse; the coin was not credited.
- deny  out  1  one-cycle pulse; select was made with insufficient credit.
- credit  out  CREDIT_W  current credit in cents.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset: all outputs 0, credit 0, state IDLE, coin-previous register 0. Reset mid-operation (including mid-CHANGE) discards credit immediately; no pending pulses survive.
- Coin acceptance: a coin counts once, on the rising edge where coin≠0 and the previous sample was 0. Credit is visible the following cycle. Holding a code across several cycles counts once.
- Reject: if credit + value > MAX_CREDIT, or the state is VEND/CHANGE, pulse coin_reject in the next cycle; credit is unchanged.
- FSM states:
  - IDLE (credit==0): accepted coin → ACCUM. select → deny. cancel is ignored.
  - ACCUM: coins accumulate. Priority: cancel > select > coin.
    - cancel → CHANGE.
    - select: lowest-index set bit wins. If credit ≥ price[i] → VEND(i); otherwise pulse deny and stay in ACCUM.
    - A coin edge in the same cycle as select: the coin is credited and the select is judged on pre-coin credit.
  - VEND: one cycle. vend[i]=1 and credit -= price[i]. Remainder >0 → CHANGE, else → IDLE.
  - CHANGE: change_nickel=1 every cycle, credit -= 5 per cycle, until credit is 0 → IDLE. Latency equals credit/5 cycles. select and cancel are ignored here.
- Outputs are registered. vend and change_nickel are never high in the same cycle.
- Credit never exceeds MAX_CREDIT and never underflows.

Optional Feature:
- VEND_AUTO_SELECT_EN
  - Defined: in ACCUM, when credit ≥ price[0] and no select or cancel is present, the block enters VEND(0) automatically. This reproduces the legacy newspaper behaviour of dispensing on reaching the price.
  - Undefined: vending occurs only on select.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, ACCUM, VEND, CHANGE);
  - coin code constants COIN_NONE/5/10/25;
  - coin value function;
  - NICKEL = 5.
- Sub-module vend_coin_decode: coin edge detect plus value lookup. Outputs coin_valid and coin_value (CREDIT_W).

Test Plan:
- Hold reset low 50, release. Insert three 5c coins, then pulse select[0] → credit reads 15, vend[0] pulses once, credit 0, no change_nickel.
- Insert 5c, 10c, 25c (credit 40), then select[1] → vend[1] pulses, then 4 consecutive change_nickel pulses, busy high throughout, final credit 0.
- Insert 10c, select[1] → deny pulses, credit remains 10. Then cancel → 2 change_nickel pulses, state IDLE.
- Bring credit to 90, insert 25c → coin_reject pulses, credit stays 90. Insert 10c → credit 100.
- Credit 40 with select[1]: assert reset after the first of 4 nickel pulses → all outputs 0 asynchronously, credit 0 after release.
- VEND_AUTO_SELECT_EN build: insert 5c then 10c with no select → vend[0] pulses the cycle after credit reaches 15. Hold coin=1 for 3 cycles → credited only once.
